// File: rtl/adder_checker.sv
// adder_checker: scoreboard that pairs each sampled operand vector with the DUT sum dut_latency edges later.
// Optional macro ADDER_CHECKER_STOP_ON_FAIL_EN: enter HALT on the first mismatch and freeze until reset.
module adder_checker #(
  parameter int data_width  = 8,
  parameter int dut_latency = 1,
  parameter int cnt_width   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [data_width-1:0] op_a,
  input  logic [data_width-1:0] op_b,
  input  logic [data_width:0]   dut_sum,
  output logic [cnt_width-1:0]  pass_cnt,
  output logic [cnt_width-1:0]  fail_cnt,
  output logic                  mismatch,
  output logic [data_width-1:0] fail_a,
  output logic [data_width-1:0] fail_b,
  output logic [data_width:0]   fail_sum,
  output logic                  busy
);

  localparam int                   last_stage = dut_latency - 1;
  localparam logic [cnt_width-1:0] cnt_max    = {cnt_width{1'b1}};
  localparam logic [cnt_width-1:0] cnt_one    = {{(cnt_width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [dut_latency-1:0] vld_r;
  logic [dut_latency-1:0] vld_s;
  logic [data_width-1:0]  a_r   [dut_latency];
  logic [data_width-1:0]  b_r   [dut_latency];
  logic [data_width:0]    exp_r [dut_latency];
  logic [data_width:0]    exp_s;
  logic                   halt_s;
  logic                   stop_s;
  logic                   accept_s;
  logic                   cmp_s;
  logic                   pass_s;
  logic                   fail_s;
  logic                   captured_r;

  assign exp_s = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
  assign halt_s = (state_r == HALT);
  assign stop_s = fail_s;
`else
  assign halt_s = 1'b0;
  assign stop_s = 1'b0;
`endif

  assign accept_s = en & ~halt_s;
  assign cmp_s    = vld_r[last_stage] & ~halt_s;
  assign pass_s   = cmp_s & (dut_sum == exp_r[last_stage]);
  assign fail_s   = cmp_s & (dut_sum != exp_r[last_stage]);

  // Next FSM state and next pipeline valid vector; a halting mismatch flushes the pipeline.
  always_comb begin
    state_s = state_r;
    vld_s   = {dut_latency{1'b0}};
    if (stop_s) begin
      state_s = HALT;
    end else begin
      vld_s[0] = accept_s;
      for (int i = 1; i < dut_latency; i++) begin
        vld_s[i] = vld_r[i-1];
      end
      case (state_r)
        IDLE: begin
          if (en) state_s = RUN;
          else    state_s = IDLE;
        end
        RUN: begin
          if (!(|vld_r) && !en) state_s = IDLE;
          else                  state_s = RUN;
        end
        HALT:    state_s = HALT;
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM state, in-flight vector pipeline and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      vld_r   <= {dut_latency{1'b0}};
      busy    <= 1'b0;
      for (int i = 0; i < dut_latency; i++) begin
        a_r[i]   <= {data_width{1'b0}};
        b_r[i]   <= {data_width{1'b0}};
        exp_r[i] <= {(data_width+1){1'b0}};
      end
    end else begin
      state_r  <= state_s;
      vld_r    <= vld_s;
      busy     <= |vld_s;
      a_r[0]   <= op_a;
      b_r[0]   <= op_b;
      exp_r[0] <= exp_s;
      for (int i = 1; i < dut_latency; i++) begin
        a_r[i]   <= a_r[i-1];
        b_r[i]   <= b_r[i-1];
        exp_r[i] <= exp_r[i-1];
      end
    end
  end

  // Saturating result counters, mismatch pulse and first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt   <= {cnt_width{1'b0}};
      fail_cnt   <= {cnt_width{1'b0}};
      mismatch   <= 1'b0;
      fail_a     <= {data_width{1'b0}};
      fail_b     <= {data_width{1'b0}};
      fail_sum   <= {(data_width+1){1'b0}};
      captured_r <= 1'b0;
    end else begin
      mismatch <= fail_s;
      if (pass_s && (pass_cnt != cnt_max)) pass_cnt <= pass_cnt + cnt_one;
      if (fail_s && (fail_cnt != cnt_max)) fail_cnt <= fail_cnt + cnt_one;
      if (fail_s && !captured_r) begin
        captured_r <= 1'b1;
        fail_a     <= a_r[last_stage];
        fail_b     <= b_r[last_stage];
        fail_sum   <= dut_sum;
      end
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed bench for adder_checker at latency 1, latency 3 and a 2-bit counter width.
// Expectations switch to the halting behaviour when ADDER_CHECKER_STOP_ON_FAIL_EN is defined.
module tb_adder_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1, en2, en3, drop;
  logic [7:0] op_a, op_b;
  logic [8:0] sum1_q;
  logic [8:0] sum3_q [3];
  logic [8:0] dut_sum1;

  logic [15:0] pass1, fail1, pass3, fail3;
  logic [1:0]  pass2, fail2;
  logic        mm1, mm2, mm3, busy1, busy2, busy3;
  logic [7:0]  fa1, fb1, fa2, fb2, fa3, fb3;
  logic [8:0]  fs1, fs2, fs3;

  int tests   = 0;
  int fails   = 0;
  int mm_seen = 0;
  logic [7:0] en_pat   = 8'b0000_1101;
  logic [7:0] exp_busy = 8'b0011_1111;

  always #5 clk = ~clk;

  // Reference adders with one-edge and three-edge output delay.
  always @(posedge clk) begin
    sum1_q    <= {1'b0, op_a} + {1'b0, op_b};
    sum3_q[0] <= {1'b0, op_a} + {1'b0, op_b};
    sum3_q[1] <= sum3_q[0];
    sum3_q[2] <= sum3_q[1];
  end

  assign dut_sum1 = drop ? {1'b0, sum1_q[7:0]} : sum1_q;

  adder_checker u1 (
    .clk(clk), .rst(rst), .en(en1), .op_a(op_a), .op_b(op_b), .dut_sum(dut_sum1),
    .pass_cnt(pass1), .fail_cnt(fail1), .mismatch(mm1), .fail_a(fa1), .fail_b(fb1),
    .fail_sum(fs1), .busy(busy1)
  );

  adder_checker #(.cnt_width(2)) u2 (
    .clk(clk), .rst(rst), .en(en2), .op_a(op_a), .op_b(op_b), .dut_sum(sum1_q),
    .pass_cnt(pass2), .fail_cnt(fail2), .mismatch(mm2), .fail_a(fa2), .fail_b(fb2),
    .fail_sum(fs2), .busy(busy2)
  );

  adder_checker #(.dut_latency(3)) u3 (
    .clk(clk), .rst(rst), .en(en3), .op_a(op_a), .op_b(op_b), .dut_sum(sum3_q[2]),
    .pass_cnt(pass3), .fail_cnt(fail3), .mismatch(mm3), .fail_a(fa3), .fail_b(fb3),
    .fail_sum(fs3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e1, input logic e2, input logic e3,
                      input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    mm_seen = mm_seen + 32'(mm1);
    en1  = e1;
    en2  = e2;
    en3  = e3;
    op_a = a;
    op_b = b;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; drop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mm_seen = 0;
  endtask

  task automatic zero_checks(input string pfx);
    check({pfx, "_pass1"}, 32'(pass1), 32'd0);
    check({pfx, "_fail1"}, 32'(fail1), 32'd0);
    check({pfx, "_mm1"},   32'(mm1),   32'd0);
    check({pfx, "_fa1"},   32'(fa1),   32'd0);
    check({pfx, "_fb1"},   32'(fb1),   32'd0);
    check({pfx, "_fs1"},   32'(fs1),   32'd0);
    check({pfx, "_busy1"}, 32'(busy1), 32'd0);
    check({pfx, "_pass2"}, 32'(pass2), 32'd0);
    check({pfx, "_fail2"}, 32'(fail2), 32'd0);
    check({pfx, "_mm2"},   32'(mm2),   32'd0);
    check({pfx, "_f2"},    32'({fa2, fb2, fs2[0]}), 32'd0);
    check({pfx, "_fs2"},   32'(fs2),   32'd0);
    check({pfx, "_busy2"}, 32'(busy2), 32'd0);
    check({pfx, "_pass3"}, 32'(pass3), 32'd0);
    check({pfx, "_fail3"}, 32'(fail3), 32'd0);
    check({pfx, "_mm3"},   32'(mm3),   32'd0);
    check({pfx, "_f3"},    32'({fa3, fb3}), 32'd0);
    check({pfx, "_fs3"},   32'(fs3),   32'd0);
    check({pfx, "_busy3"}, 32'(busy3), 32'd0);
  endtask

  initial begin
    rst = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; drop = 1'b0;
    op_a = 8'd0; op_b = 8'd0;
    repeat (2) @(negedge clk);
    zero_checks("rst");
    rst = 1'b1;

    // Latency 1, correct DUT, back-to-back vectors including carry cases.
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 8'd3,   8'd4);
    tick(1'b1, 1'b0, 1'b0, 8'd255, 8'd1);
    tick(1'b1, 1'b0, 1'b0, 8'd128, 8'd128);
    tick(1'b1, 1'b0, 1'b0, 8'd0,   8'd0);
    check("s1_busy_mid", 32'(busy1), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check("s1_pass", 32'(pass1), 32'd4);
    check("s1_fail", 32'(fail1), 32'd0);
    check("s1_mm_pulses", 32'(mm_seen), 32'd0);
    check("s1_busy_end", 32'(busy1), 32'd0);

    // DUT drops its carry-out.
    do_reset();
    drop = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'd255, 8'd1);
    tick(1'b1, 1'b0, 1'b0, 8'd200, 8'd100);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
    check("s2_fail", 32'(fail1), 32'd1);
    check("s2_mm_pulses", 32'(mm_seen), 32'd1);
`else
    check("s2_fail", 32'(fail1), 32'd2);
    check("s2_mm_pulses", 32'(mm_seen), 32'd2);
`endif
    check("s2_pass", 32'(pass1), 32'd0);
    check("s2_fail_a", 32'(fa1), 32'd255);
    check("s2_fail_b", 32'(fb1), 32'd1);
    check("s2_fail_sum", 32'(fs1), 32'd0);
    check("s2_mm_low", 32'(mm1), 32'd0);
    drop = 1'b0;

    // Latency 3, gapped en pattern 1,0,1,1; busy traced edge by edge.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tick(1'b0, 1'b0, en_pat[i], 8'(10 * i + 1), 8'(40 * i + 7));
      else       tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      if (i > 0) check($sformatf("s3_busy_e%0d", i - 1), 32'(busy3), 32'(exp_busy[i-1]));
    end
    check("s3_pass", 32'(pass3), 32'd3);
    check("s3_fail", 32'(fail3), 32'd0);

    // Reset pulse with two vectors in flight at latency 3.
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 8'd5, 8'd6);
    tick(1'b0, 1'b0, 1'b1, 8'd7, 8'd8);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check("s4_busy_pre", 32'(busy3), 32'd1);
    #1 rst = 1'b0;
    #1 zero_checks("s4_in_rst");
    rst = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check("s4_pass_after", 32'(pass3), 32'd0);
    check("s4_fail_after", 32'(fail3), 32'd0);
    check("s4_busy_after", 32'(busy3), 32'd0);

    // Two-bit counters saturate at 3.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 8'(i * 50), 8'(i + 1));
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check("s5_pass_sat", 32'(pass2), 32'd3);
    check("s5_fail", 32'(fail2), 32'd0);

    // Mismatch on vector 2 of 5 (only that vector carries out).
    do_reset();
    drop = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'd1,   8'd2);
    tick(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
    tick(1'b1, 1'b0, 1'b0, 8'd3,   8'd3);
    tick(1'b1, 1'b0, 1'b0, 8'd4,   8'd4);
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
    check("s6_busy_halt", 32'(busy1), 32'd0);
`else
    check("s6_busy_run", 32'(busy1), 32'd1);
`endif
    tick(1'b1, 1'b0, 1'b0, 8'd5, 8'd5);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
`ifdef ADDER_CHECKER_STOP_ON_FAIL_EN
    check("s6_pass", 32'(pass1), 32'd1);
`else
    check("s6_pass", 32'(pass1), 32'd4);
`endif
    check("s6_fail", 32'(fail1), 32'd1);
    check("s6_mm_pulses", 32'(mm_seen), 32'd1);
    check("s6_busy_end", 32'(busy1), 32'd0);
    check("s6_fail_a", 32'(fa1), 32'd255);
    check("s6_fail_b", 32'(fb1), 32'd255);
    check("s6_fail_sum", 32'(fs1), 32'd254);
    drop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
